// File: rtl/fsm_secure_lock_if.sv
// Control-input / mode-output bundle for fsm_secure_lock.
// SW must match the lock's state-register width (2 binary, 4 one-hot).
interface fsm_secure_lock_if #(
    parameter int SW    = 2,
    parameter int CNT_W = 8
);
    logic             A;
    logic             B;
    logic             C;
    logic             D;
    logic             fi_en;
    logic [SW-1:0]    fi_mask;
    logic [1:0]       out;
    logic             locked;
    logic             fault;
    logic [CNT_W-1:0] trans_cnt;

    modport master (
        output A, B, C, D, fi_en, fi_mask,
        input  out, locked, fault, trans_cnt
    );

    modport slave (
        input  A, B, C, D, fi_en, fi_mask,
        output out, locked, fault, trans_cnt
    );
endinterface

// File: rtl/fsm_secure_lock.sv
// Hardened IDLE/ARM/ACTIVE/LOCK control FSM with hold-qualified transitions,
// illegal-state fail-safe, fault injection and a saturating transition counter.
module fsm_secure_lock #(
    parameter bit ONEHOT      = 1'b0,
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    fsm_secure_lock_if.slave bus
);
    localparam int SW = ONEHOT ? 4 : 2;
    localparam int HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_L = HW'(HOLD_CYCLES);

    // Binary codes equal the downstream mode code, so binary decode is a pass-through.
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOCK   = 2'b01,
        S_ARM    = 2'b10,
        S_ACTIVE = 2'b11
    } state_e;

    function automatic logic [SW-1:0] enc(input state_e s);
        logic [3:0] oh;
        case (s)
            S_IDLE:  oh = 4'b0001;
            S_LOCK:  oh = 4'b0010;
            S_ARM:   oh = 4'b0100;
            default: oh = 4'b1000;
        endcase
        if (ONEHOT) return oh[SW-1:0];
        else        return SW'(s);
    endfunction

    logic [SW-1:0]    state_q;
    state_e           cand_q;
    state_e           cand_d;
    state_e           cur;
    logic             legal;
    logic [HW-1:0]    hold_q;
    logic [HW-1:0]    run_d;
    logic             advance;
    logic             fault_q;
    logic [CNT_W-1:0] cnt_q;

    generate
        if (ONEHOT) begin : g_oh
            always_comb begin
                legal = 1'b1;
                case (state_q)
                    4'b0001: cur = S_IDLE;
                    4'b0010: cur = S_LOCK;
                    4'b0100: cur = S_ARM;
                    4'b1000: cur = S_ACTIVE;
                    default: begin
                        cur   = S_LOCK;
                        legal = 1'b0;
                    end
                endcase
            end
        end else begin : g_bin
            always_comb begin
                legal = 1'b1;
                cur   = state_e'(state_q);
            end
        end
    endgenerate

    always_comb begin
        cand_d = cur;
        case (cur)
            S_IDLE:   if (bus.B || bus.D) cand_d = S_LOCK;
                      else if (bus.C)     cand_d = S_ARM;
            S_ARM:    if (bus.B || bus.D) cand_d = S_LOCK;
                      else if (bus.A)     cand_d = S_ACTIVE;
            S_ACTIVE: if (bus.D)          cand_d = S_LOCK;
                      else if (!bus.A)    cand_d = S_ARM;
            default:  cand_d = S_LOCK;
        endcase
    end

    // Lock requests bypass qualification; everything else must repeat HOLD_CYCLES edges.
    assign run_d   = (cand_d == cand_q && hold_q != '0) ? hold_q + HW'(1) : HW'(1);
    assign advance = (cand_d == S_LOCK) || (run_d >= HOLD_L);

    assign bus.out       = legal ? cur : S_LOCK;
    assign bus.locked    = !legal || (cur == S_LOCK);
    assign bus.fault     = fault_q;
    assign bus.trans_cnt = cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= enc(S_IDLE);
            cand_q  <= S_IDLE;
            hold_q  <= '0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            cand_q <= cand_d;
            if (bus.fi_en) begin
                state_q <= state_q ^ bus.fi_mask;
                hold_q  <= '0;
            end else if (!legal) begin
                state_q <= enc(S_LOCK);
                fault_q <= 1'b1;
                hold_q  <= '0;
            end else if (cand_d == cur) begin
                hold_q <= '0;
            end else if (advance) begin
                state_q <= enc(cand_d);
                hold_q  <= '0;
                if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                hold_q <= run_d;
            end
        end
    end
endmodule
